fire8_expand3_wr: RTL

FIRE8_EXPAND3_WR -- requirements
Module: fire8_expand3_wr

---
 rtl/fire8_expand3_wr.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fire8_expand3_wr.sv
// fire8_expand3_wr
// ----------------------------------------------------------------------------
// Serializes one pixel's worth of DSP_NO parallel channel results into a RAM,
// one word per cycle, using a channel-major layout (addr = ch*WOUT^2 + pix).
// After WOUT^2 pixels the layer is complete: ram_feedback pulses once and the
// block parks in DONE until reset.
//
// Ports
//   clk                   sole clock, rising edge
//   rst                   synchronous, active-high reset
//   fire8_expand3_sample  one-cycle pulse, ofm valid in that cycle
//   ofm                   DSP_NO words of WIDTH bits for the current pixel
//   ram_we                RAM write strobe
//   ram_addr              RAM write address
//   ram_data              RAM write data (addr/data hold while ram_we=0)
//   ram_feedback          one-cycle pulse, the whole layer has been written
//   busy                  high while a pixel is being serialized
//   overrun               sticky, a sample arrived while busy
//   dbg_state             current FSM state (0=IDLE, 1=WRITE, 2=DONE)
//   chksum                only with FIRE8_EXPAND3_WR_CHKSUM_EN: wrapping
//                         32-bit sum of ram_data over every ram_we cycle
//
// Handshake: fire8_expand3_sample is a valid-only pulse with no ready; it is
// accepted only in IDLE. A pulse in WRITE (including the last-channel cycle)
// is dropped and sets overrun; a pulse in DONE is silently ignored.
//
// Optional feature macro: FIRE8_EXPAND3_WR_CHKSUM_EN
// ----------------------------------------------------------------------------
module fire8_expand3_wr #(
    parameter int WOUT   = 8,
    parameter int DSP_NO = 256,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(DSP_NO * WOUT * WOUT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fire8_expand3_sample,
    input  logic [DSP_NO-1:0][WIDTH-1:0]  ofm,
    output logic                          ram_we,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [WIDTH-1:0]              ram_data,
    output logic                          ram_feedback,
    output logic                          busy,
    output logic                          overrun,
    output logic [1:0]                    dbg_state
`ifdef FIRE8_EXPAND3_WR_CHKSUM_EN
    ,
    output logic [31:0]                   chksum
`endif
);

    localparam int NPIX  = WOUT * WOUT;
    localparam int CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                         state_q;
    logic [CH_W-1:0]                ch_q;
    logic [CH_W-1:0]                ch_d;
    logic [PIX_W-1:0]               pix_q;
    logic [PIX_W-1:0]               pix_d;
    logic                           ram_we_q;
    logic [ADDR_W-1:0]              ram_addr_q;
    logic [WIDTH-1:0]               ram_data_q;
    logic                           fb_q;
    logic                           ovr_q;
    logic [DSP_NO-1:0][WIDTH-1:0]   shadow_q;

    assign ch_d  = ch_q + CH_W'(1);
    assign pix_d = pix_q + PIX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            pix_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            fb_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            fb_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fire8_expand3_sample) begin
                        // Channel 0 goes straight from the input so the
                        // first write appears the cycle after the sample.
                        state_q    <= S_WRITE;
                        ch_q       <= '0;
                        ram_we_q   <= 1'b1;
                        ram_addr_q <= ADDR_W'(pix_q);
                        ram_data_q <= ofm[0];
                    end
                end
                S_WRITE: begin
                    if (fire8_expand3_sample) begin
                        ovr_q <= 1'b1;
                    end
                    if (ch_q == CH_W'(DSP_NO - 1)) begin
                        ram_we_q <= 1'b0;
                        pix_q    <= pix_d;
                        if (pix_q == PIX_W'(NPIX - 1)) begin
                            state_q <= S_DONE;
                            fb_q    <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        // Channel-major: the next channel is one plane away.
                        ch_q       <= ch_d;
                        ram_addr_q <= ram_addr_q + ADDR_W'(NPIX);
                        ram_data_q <= shadow_q[ch_d];
                    end
                end
                default: begin
                    ram_we_q <= 1'b0;
                end
            endcase
        end
    end

    // Shadow buffer is data-only storage with no reset.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_IDLE && fire8_expand3_sample) begin
            shadow_q <= ofm;
        end
    end

`ifdef FIRE8_EXPAND3_WR_CHKSUM_EN
    logic [31:0] chksum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chksum_q <= '0;
        end else if (ram_we_q) begin
            chksum_q <= chksum_q + 32'(ram_data_q);
        end
    end

    assign chksum = chksum_q;
`endif

    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_data     = ram_data_q;
    assign ram_feedback = fb_q;
    assign overrun      = ovr_q;
    assign busy         = (state_q == S_WRITE);
    assign dbg_state    = state_q;

endmodule
